// File: rtl/ch_pkg.sv
// Shared definitions for the cluster-head advertisement exchange (transmit and receive sides).
package ch_pkg;

    localparam int unsigned WORD_WIDTH     = 16;
    localparam logic [3:0]  PKT_TYPE_CHADV = 4'hC;

    // Header word layout: {type[15:12], reserved[11:8], seq[7:0]}
    localparam int unsigned HDR_TYPE_LSB = 12;
    localparam int unsigned HDR_SEQ_LSB  = 0;

    localparam logic [WORD_WIDTH-1:0] HOPS_UNKNOWN = 16'hFFFF;

    typedef logic [2:0] adv_state_t;
    localparam adv_state_t IDLE = 3'd0;
    localparam adv_state_t HDR  = 3'd1;
    localparam adv_state_t ID   = 3'd2;
    localparam adv_state_t HOPS = 3'd3;
    localparam adv_state_t QV   = 3'd4;

    function automatic logic [WORD_WIDTH-1:0] make_header(input logic [3:0] ptype,
                                                          input logic [7:0] seq);
        logic [WORD_WIDTH-1:0] hdr;
        hdr = '0;
        hdr[HDR_TYPE_LSB +: 4] = ptype;
        hdr[HDR_SEQ_LSB +: 8]  = seq;
        return hdr;
    endfunction

endpackage

// File: rtl/ch_adv_serializer.sv
// Four-word advertisement serializer: holds each word on the valid/ready stream until accepted.
module ch_adv_serializer
    import ch_pkg::*;
#(
    parameter int unsigned DATA_W   = ch_pkg::WORD_WIDTH,
    parameter logic [3:0]  PKT_TYPE = ch_pkg::PKT_TYPE_CHADV
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [DATA_W-1:0] ch_id,
    input  logic [DATA_W-1:0] hops,
    input  logic [DATA_W-1:0] qvalue,
    input  logic [7:0]        seq,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              tx_last,
    output logic              idle
);

    adv_state_t state;
    logic       fire;

    assign fire = tx_valid && tx_ready;
    assign idle = (state == IDLE);

    always_ff @(posedge clk) begin
        if (nrst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= HDR;
                HDR:     if (fire)  state <= ID;
                ID:      if (fire)  state <= HOPS;
                HOPS:    if (fire)  state <= QV;
                QV:      if (fire)  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        tx_data  = '0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        case (state)
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = DATA_W'(make_header(PKT_TYPE, seq));
            end
            ID: begin
                tx_valid = 1'b1;
                tx_data  = ch_id;
            end
            HOPS: begin
                tx_valid = 1'b1;
                tx_data  = hops;
            end
            QV: begin
                tx_valid = 1'b1;
                tx_data  = qvalue;
                tx_last  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ch_advertiser.sv
// CH advertisement transmitter: originate/relay arbitration, pending originate slot,
// per-round relay limiting and packet sequence numbering.
module ch_advertiser #(
    parameter int unsigned WORD_WIDTH = ch_pkg::WORD_WIDTH,
    parameter int unsigned MAX_HOPS   = 8,
    parameter logic [3:0]  PKT_TYPE   = ch_pkg::PKT_TYPE_CHADV
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en_CHadv,
    input  logic [WORD_WIDTH-1:0] node_ID,
    input  logic [WORD_WIDTH-1:0] node_QValue,
    input  logic                  en_relay,
    input  logic [WORD_WIDTH-1:0] fCH_ID,
    input  logic [WORD_WIDTH-1:0] fCH_Hops,
    input  logic [WORD_WIDTH-1:0] fCH_QValue,
    input  logic                  HB_reset,
    input  logic [WORD_WIDTH-1:0] HB_CHlimit,
    output logic [WORD_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    output logic                  busy,
    output logic                  relay_dropped
);

    localparam logic [WORD_WIDTH-1:0] MAX_HOPS_W = WORD_WIDTH'(MAX_HOPS);

    logic [WORD_WIDTH-1:0] cap_id, cap_hops, cap_qv;
    logic [WORD_WIDTH-1:0] pend_id, pend_qv;
    logic [WORD_WIDTH-1:0] relay_cnt, cnt_base, cnt_next;
    logic [7:0]            seq;
    logic                  pending_orig;
    logic                  idle, start;
    logic                  take_pend, take_orig, take_relay;

    // A heartbeat in the same cycle clears the count before the limit check.
    assign cnt_base   = HB_reset ? '0 : relay_cnt;
    assign cnt_next   = (cnt_base == '1) ? cnt_base : cnt_base + WORD_WIDTH'(1);

    assign take_pend  = idle && pending_orig;
    assign take_orig  = idle && !pending_orig && en_CHadv;
    assign take_relay = idle && !pending_orig && !en_CHadv && en_relay
                        && (fCH_Hops < MAX_HOPS_W) && (cnt_base < HB_CHlimit);
    assign start      = take_pend || take_orig || take_relay;
    assign busy       = !idle || pending_orig;

    always_ff @(posedge clk) begin
        if (nrst) begin
            cap_id        <= '0;
            cap_hops      <= '0;
            cap_qv        <= '0;
            pend_id       <= '0;
            pend_qv       <= '0;
            pending_orig  <= 1'b0;
            relay_cnt     <= '0;
            seq           <= '0;
            relay_dropped <= 1'b0;
        end else begin
            relay_dropped <= en_relay && !take_relay;
            relay_cnt     <= take_relay ? cnt_next : cnt_base;

            if (tx_valid && tx_ready && tx_last)
                seq <= seq + 8'd1;

            if (take_pend) begin
                cap_id   <= pend_id;
                cap_hops <= '0;
                cap_qv   <= pend_qv;
            end else if (take_orig) begin
                cap_id   <= node_ID;
                cap_hops <= '0;
                cap_qv   <= node_QValue;
            end else if (take_relay) begin
                cap_id   <= fCH_ID;
                cap_hops <= fCH_Hops + WORD_WIDTH'(1);
                cap_qv   <= fCH_QValue;
            end

            // An originate arriving while the slot is being served refills it.
            if (en_CHadv && !take_orig) begin
                pending_orig <= 1'b1;
                pend_id      <= node_ID;
                pend_qv      <= node_QValue;
            end else if (take_pend) begin
                pending_orig <= 1'b0;
            end
        end
    end

    ch_adv_serializer #(
        .DATA_W   (WORD_WIDTH),
        .PKT_TYPE (PKT_TYPE)
    ) u_ser (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start),
        .ch_id    (cap_id),
        .hops     (cap_hops),
        .qvalue   (cap_qv),
        .seq      (seq),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .idle     (idle)
    );

endmodule

// File: tb/tb_ch_advertiser.sv
// Directed self-checking bench for ch_advertiser.
module tb_ch_advertiser;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en_CHadv;
    logic [15:0] node_ID, node_QValue;
    logic        en_relay;
    logic [15:0] fCH_ID, fCH_Hops, fCH_QValue;
    logic        HB_reset;
    logic [15:0] HB_CHlimit;
    logic [15:0] tx_data;
    logic        tx_valid, tx_ready, tx_last, busy, relay_dropped;

    int tests = 0;
    int fails = 0;

    ch_advertiser #(
        .WORD_WIDTH (16),
        .MAX_HOPS   (8),
        .PKT_TYPE   (4'hC)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .en_CHadv      (en_CHadv),
        .node_ID       (node_ID),
        .node_QValue   (node_QValue),
        .en_relay      (en_relay),
        .fCH_ID        (fCH_ID),
        .fCH_Hops      (fCH_Hops),
        .fCH_QValue    (fCH_QValue),
        .HB_reset      (HB_reset),
        .HB_CHlimit    (HB_CHlimit),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_last       (tx_last),
        .busy          (busy),
        .relay_dropped (relay_dropped)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] data, input logic last);
        chk1({tag, ".valid"}, tx_valid, 1'b1);
        chk16({tag, ".data"}, tx_data, data);
        chk1({tag, ".last"}, tx_last, last);
    endtask

    // Called one cycle after an accepted request; returns in the cycle after the last word.
    task automatic pkt(input string tag, input logic [15:0] h, input logic [15:0] i,
                       input logic [15:0] o, input logic [15:0] q);
        chk_word({tag, ".w0"}, h, 1'b0); step();
        chk_word({tag, ".w1"}, i, 1'b0); step();
        chk_word({tag, ".w2"}, o, 1'b0); step();
        chk_word({tag, ".w3"}, q, 1'b1); step();
        chk1({tag, ".after"}, tx_valid, 1'b0);
    endtask

    task automatic relay(input logic [15:0] id, input logic [15:0] hops, input logic [15:0] q);
        en_relay   = 1'b1;
        fCH_ID     = id;
        fCH_Hops   = hops;
        fCH_QValue = q;
    endtask

    initial begin
        nrst = 1'b1; en_CHadv = 1'b0; en_relay = 1'b0; HB_reset = 1'b0;
        node_ID = '0; node_QValue = '0; fCH_ID = '0; fCH_Hops = '0; fCH_QValue = '0;
        HB_CHlimit = '0; tx_ready = 1'b1;
        step(); step();

        chk1("rst.valid", tx_valid, 1'b0);
        chk16("rst.data", tx_data, 16'h0000);
        chk1("rst.last", tx_last, 1'b0);
        chk1("rst.busy", busy, 1'b0);
        chk1("rst.drop", relay_dropped, 1'b0);
        nrst = 1'b0;
        step();

        // Originate; inputs changed after accept must not leak into the packet
        en_CHadv = 1'b1; node_ID = 16'd23; node_QValue = 16'h3000;
        step();
        en_CHadv = 1'b0; node_ID = 16'd99; node_QValue = 16'h9999;
        chk1("orig.busy", busy, 1'b1);
        pkt("orig", 16'hC000, 16'd23, 16'd0, 16'h3000);
        chk1("orig.idle_busy", busy, 1'b0);

        // Relays: limit 3 per round
        HB_reset = 1'b1; HB_CHlimit = 16'd3;
        relay(16'd45, 16'd2, 16'h2000);
        step();
        en_relay = 1'b0; HB_reset = 1'b0;
        chk1("r1.drop", relay_dropped, 1'b0);
        pkt("r1", 16'hC001, 16'd45, 16'd3, 16'h2000);
        relay(16'd46, 16'd5, 16'h2100);
        step();
        en_relay = 1'b0;
        pkt("r2", 16'hC002, 16'd46, 16'd6, 16'h2100);
        relay(16'd47, 16'd0, 16'h2200);
        step();
        en_relay = 1'b0;
        pkt("r3", 16'hC003, 16'd47, 16'd1, 16'h2200);
        relay(16'd48, 16'd1, 16'h2300);
        step();
        chk1("r4.drop", relay_dropped, 1'b1);
        chk1("r4.valid", tx_valid, 1'b0);
        step();
        en_relay = 1'b0;
        chk1("r5.drop", relay_dropped, 1'b1);
        chk1("r5.valid", tx_valid, 1'b0);
        step();
        chk1("r5.drop_clr", relay_dropped, 1'b0);

        // Heartbeat with a relay in the same cycle: accepted, count becomes 1
        HB_reset = 1'b1;
        relay(16'd49, 16'd3, 16'h2400);
        step();
        HB_reset = 1'b0; en_relay = 1'b0;
        chk1("hb.drop", relay_dropped, 1'b0);
        pkt("hb", 16'hC004, 16'd49, 16'd4, 16'h2400);

        // Backpressure on the HOPS word (count 1 -> 2)
        relay(16'd45, 16'd2, 16'h2000);
        step();
        en_relay = 1'b0;
        chk_word("bp.w0", 16'hC005, 1'b0); step();
        chk_word("bp.w1", 16'd45, 1'b0); step();
        chk_word("bp.w2", 16'd3, 1'b0);
        tx_ready = 1'b0;
        step(); chk_word("bp.hold1", 16'd3, 1'b0);
        step(); chk_word("bp.hold2", 16'd3, 1'b0);
        step(); chk_word("bp.hold3", 16'd3, 1'b0);
        tx_ready = 1'b1;
        step(); chk_word("bp.w3", 16'h2000, 1'b1);
        step(); chk1("bp.after", tx_valid, 1'b0);

        // Originate and relay together: originate wins, relay dropped
        en_CHadv = 1'b1; node_ID = 16'd11; node_QValue = 16'h0AAA;
        relay(16'd50, 16'd1, 16'h2500);
        step();
        en_CHadv = 1'b0; en_relay = 1'b0;
        chk1("col.drop", relay_dropped, 1'b1);
        pkt("col", 16'hC006, 16'd11, 16'd0, 16'h0AAA);

        // Originates while busy queue one entry, newest wins, one IDLE gap
        en_CHadv = 1'b1; node_ID = 16'd1; node_QValue = 16'h0111;
        step();
        en_CHadv = 1'b0;
        chk_word("q.w0", 16'hC007, 1'b0); step();
        chk_word("q.w1", 16'd1, 1'b0);
        en_CHadv = 1'b1; node_ID = 16'd2; node_QValue = 16'h0222;
        step();
        chk_word("q.w2", 16'd0, 1'b0);
        node_ID = 16'd4; node_QValue = 16'h0444;
        step();
        en_CHadv = 1'b0; node_ID = 16'd3; node_QValue = 16'h0333;
        chk_word("q.w3", 16'h0111, 1'b1); step();
        chk1("q.gap_valid", tx_valid, 1'b0);
        chk1("q.gap_busy", busy, 1'b1);
        step();
        pkt("q2", 16'hC008, 16'd4, 16'd0, 16'h0444);

        // Bad hop counts are dropped without touching the relay count (still 2)
        relay(16'd60, ch_pkg::HOPS_UNKNOWN, 16'h2600);
        step();
        en_relay = 1'b0;
        chk1("ffff.drop", relay_dropped, 1'b1);
        chk1("ffff.valid", tx_valid, 1'b0);
        step();
        chk1("ffff.valid2", tx_valid, 1'b0);
        relay(16'd61, 16'd8, 16'h2700);
        step();
        en_relay = 1'b0;
        chk1("max.drop", relay_dropped, 1'b1);
        chk1("max.valid", tx_valid, 1'b0);
        step();
        chk1("max.valid2", tx_valid, 1'b0);
        relay(16'd62, 16'd7, 16'h2800);
        step();
        en_relay = 1'b0;
        chk1("h7.drop", relay_dropped, 1'b0);
        pkt("h7", 16'hC009, 16'd62, 16'd8, 16'h2800);
        relay(16'd63, 16'd1, 16'h2900);
        step();
        en_relay = 1'b0;
        chk1("lim.drop", relay_dropped, 1'b1);
        chk1("lim.valid", tx_valid, 1'b0);

        // Limit 0 disables relaying even right after a heartbeat
        HB_reset = 1'b1; HB_CHlimit = 16'd0;
        relay(16'd64, 16'd1, 16'h2A00);
        step();
        HB_reset = 1'b0; en_relay = 1'b0; HB_CHlimit = 16'd3;
        chk1("lim0.drop", relay_dropped, 1'b1);
        chk1("lim0.valid", tx_valid, 1'b0);
        step();

        // Reset mid-packet aborts and clears seq
        en_CHadv = 1'b1; node_ID = 16'd5; node_QValue = 16'h0555;
        step();
        en_CHadv = 1'b0;
        chk_word("mr.w0", 16'hC00A, 1'b0); step();
        chk_word("mr.w1", 16'd5, 1'b0);
        nrst = 1'b1;
        step();
        nrst = 1'b0;
        chk1("mr.valid", tx_valid, 1'b0);
        chk1("mr.busy", busy, 1'b0);
        chk16("mr.data", tx_data, 16'h0000);
        step();
        chk1("mr.noresume", tx_valid, 1'b0);
        en_CHadv = 1'b1; node_ID = 16'd6; node_QValue = 16'h0666;
        step();
        en_CHadv = 1'b0;
        pkt("mr.next", 16'hC000, 16'd6, 16'd0, 16'h0666);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
